uart_rx_buffered: RTL

//  Serial-side receive endpoint for the UART link: recovers 8N1-style frames from rx, validates start
//  and stop bits with 3-sample majority voting, and queues received words in a small FIFO drained

---
 rtl/uart_rx_buffered_pkg.sv | 16 +
 rtl/uart_rx_buffered_sync_fifo.sv | 58 +++++
 rtl/uart_rx_buffered.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and the
// 3-sample majority helper used for bit decisions.
package uart_rx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted only when a pop happens in the same cycle;
// otherwise it is ignored and the contents stay unchanged.
module uart_rx_buffered_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver: synchronizes rx, recovers LSB-first frames using a
// 3-sample majority vote around mid-bit, and queues good words in a FIFO.
// Handshake: a word is transferred on every cycle where data_valid && data_ready
// are both high; data_valid never drops without a transfer, and data_ready
// while data_valid is low has no effect.
module uart_rx_buffered
  import uart_rx_buffered_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rx,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    state_dbg
);

  localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int MID   = CLOCKS_PER_PULSE / 2;
  localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic                  rx_meta, rx_s, rx_s_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  push_req, push_d, ferr_d;
  logic                  bit_val, is_dec, is_end;
  logic                  pop, fifo_full, fifo_empty;

  assign bit_val    = majority3(s0_q, s1_q, rx_s);
  assign is_dec     = (cnt_q == CNT_DEC);
  assign is_end     = (cnt_q == CNT_END);
  assign data_valid = !fifo_empty;
  assign pop        = data_valid && data_ready;
  assign state_dbg  = state_q;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Next-state logic: bit timing, majority sampling, shifting and frame outcome.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    if (state_q != IDLE) begin
      cnt_d = is_end ? '0 : cnt_q + 1'b1;
      if (cnt_q == CNT_S0) s0_d = rx_s;
      if (cnt_q == CNT_S1) s1_d = rx_s;
    end
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_s_d && !rx_s) state_d = START;
      end
      START: begin
        if (is_dec && bit_val) begin
          state_d = IDLE;
        end else if (is_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (is_dec) sr_d[idx_q] = bit_val;
        if (is_end) begin
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start bit is caught without gaps.
        if (is_dec) begin
          if (bit_val) push_d = 1'b1;
          else         ferr_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; push and error requests land one cycle after the decision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sr_q      <= '0;
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sr_q      <= sr_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      push_req  <= push_d;
      frame_err <= ferr_d;
      overrun   <= push_req && fifo_full && !pop;
    end
  end

  uart_rx_buffered_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_req),
    .push_data (sr_q),
    .pop       (pop),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
